// File: rtl/nfa_pkg.sv
// Shared definitions for the NFA payload engines: decoder class indices and CLASS_SEL packing helpers.
package nfa_pkg;

    localparam int CLS_W     = 6;
    localparam int MAX_PAT   = 32;
    localparam int SEL_MAX_W = MAX_PAT * CLS_W;

    // Bit positions on the shared char-decoder bus; letters are case-sensitive ranges.
    typedef enum int {
        CLS_SPACE   = 0,
        CLS_DOT     = 1,
        CLS_LPAREN  = 2,
        CLS_LOWER_A = 10,
        CLS_UPPER_A = 36,
        CLS_OTHER   = 63
    } char_class_e;

    function automatic int cls_idx_width(input int num_classes);
        return (num_classes <= 2) ? 1 : $clog2(num_classes);
    endfunction

    function automatic int char_to_class(input logic [7:0] ch);
        if (ch == 8'h20 || ch == 8'h09 || ch == 8'h0a || ch == 8'h0d) return CLS_SPACE;
        if (ch == 8'h2e) return CLS_DOT;
        if (ch == 8'h28) return CLS_LPAREN;
        if (ch >= 8'h61 && ch <= 8'h7a) return CLS_LOWER_A + int'(ch - 8'h61);
        if (ch >= 8'h41 && ch <= 8'h5a) return CLS_UPPER_A + int'(ch - 8'h41);
        return CLS_OTHER;
    endfunction

    // The pattern is a string literal; its first character lands in field 0.
    function automatic logic [SEL_MAX_W-1:0] pack_class_sel(input logic [8*MAX_PAT-1:0] pat,
                                                            input int len);
        logic [SEL_MAX_W-1:0] sel;
        sel = '0;
        for (int k = 0; k < len; k++) begin
            sel[k*CLS_W +: CLS_W] = CLS_W'(char_to_class(pat[8*(len-1-k) +: 8]));
        end
        return sel;
    endfunction

endpackage

// File: rtl/nfa_chain_state.sv
// One non-final chain state: class gate, optional zero-or-more loop and the state flop.
module nfa_chain_state
    import nfa_pkg::*;
#(
    parameter logic LOOP = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sod,
    input  logic en,
    input  logic cls,
    input  logic entry,
    output logic entry_next
);

    logic state;
    logic state_eff;
    logic reach;

    // A coincident sod makes the byte see an empty chain.
    assign state_eff  = state & ~sod;
    assign reach      = LOOP ? (entry | state_eff) : entry;
    assign entry_next = LOOP ? (entry | state_eff) : state_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 1'b0;
        end else if (en) begin
            state <= cls & reach;
        end else if (sod) begin
            state <= 1'b0;
        end
    end

endmodule

// File: rtl/nfa_chain_engine.sv
// Linear NFA payload matcher with sticky match, hit count and byte offset.
// Optional NFA_MATCH_OFFSET_EN adds match_offset (index of the first hit byte).
module nfa_chain_engine
    import nfa_pkg::*;
#(
    parameter int                                NUM_STATES  = 40,
    parameter int                                NUM_CLASSES = 64,
    parameter int                                CLS_IDX_W   = 6,
    parameter logic [NUM_STATES*CLS_IDX_W-1:0]   CLASS_SEL   = '0,
    parameter logic [NUM_STATES-1:0]             LOOP_MASK   = '0,
    parameter bit                                ANCHORED    = 1'b0,
    parameter int                                OFF_W       = 16,
    parameter int                                CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sod,
    input  logic                   en,
    input  logic [NUM_CLASSES-1:0] char_class,
    output logic                   match,
    output logic                   match_pulse,
    output logic [CNT_W-1:0]       match_cnt,
    output logic [OFF_W-1:0]       byte_off
`ifdef NFA_MATCH_OFFSET_EN
    ,
    output logic [OFF_W-1:0]       match_offset
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OFF_W-1:0] OFF_MAX = '1;

    logic [NUM_STATES-1:0] cls;
    logic [NUM_STATES-1:0] entry;
    logic                  hit;
    logic                  match_eff;
    logic [CNT_W-1:0]      cnt_eff;
    logic [OFF_W-1:0]      off_eff;

    for (genvar k = 0; k < NUM_STATES; k++) begin : g_cls
        assign cls[k] = char_class[CLASS_SEL[k*CLS_IDX_W +: CLS_IDX_W]];
    end

    assign entry[0] = ANCHORED ? (en & (sod | (byte_off == '0))) : 1'b1;

    for (genvar k = 0; k < NUM_STATES - 1; k++) begin : g_state
        nfa_chain_state #(
            .LOOP (LOOP_MASK[k])
        ) u_state (
            .clk        (clk),
            .rst_n      (rst_n),
            .sod        (sod),
            .en         (en),
            .cls        (cls[k]),
            .entry      (entry[k]),
            .entry_next (entry[k+1])
        );
    end

    // The final state only needs storage when it can repeat.
    if (LOOP_MASK[NUM_STATES-1]) begin : g_last_loop
        logic s_last;
        logic reach;
        assign reach = entry[NUM_STATES-1] | (s_last & ~sod);
        assign hit   = en & cls[NUM_STATES-1] & reach;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_last <= 1'b0;
            end else if (en) begin
                s_last <= cls[NUM_STATES-1] & reach;
            end else if (sod) begin
                s_last <= 1'b0;
            end
        end
    end else begin : g_last_plain
        assign hit = en & cls[NUM_STATES-1] & entry[NUM_STATES-1];
    end

    assign match_eff = match & ~sod;
    assign cnt_eff   = sod ? '0 : match_cnt;
    assign off_eff   = sod ? '0 : byte_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match       <= 1'b0;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
            byte_off    <= '0;
        end else if (en) begin
            match_pulse <= hit;
            match       <= match_eff | hit;
            match_cnt   <= (hit && cnt_eff != CNT_MAX) ? cnt_eff + 1'b1 : cnt_eff;
            byte_off    <= (off_eff == OFF_MAX) ? off_eff : off_eff + 1'b1;
        end else begin
            match_pulse <= 1'b0;
            if (sod) begin
                match     <= 1'b0;
                match_cnt <= '0;
                byte_off  <= '0;
            end
        end
    end

`ifdef NFA_MATCH_OFFSET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_offset <= '0;
        end else if (en) begin
            match_offset <= (hit && !match_eff) ? off_eff : (sod ? '0 : match_offset);
        end else if (sod) begin
            match_offset <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_nfa_chain_engine.sv
// Directed bench for nfa_chain_engine: several pattern instances share one byte stream.
module tb_nfa_chain_engine;
    import nfa_pkg::*;

    localparam logic [8*MAX_PAT-1:0] PAT_AX  = (8*MAX_PAT)'("new ActiveXObject(");
    localparam logic [8*MAX_PAT-1:0] PAT_AA  = (8*MAX_PAT)'("aa");
    localparam logic [8*MAX_PAT-1:0] PAT_AB  = (8*MAX_PAT)'("ab");
    localparam logic [8*MAX_PAT-1:0] PAT_A   = (8*MAX_PAT)'("a");
    localparam logic [SEL_MAX_W-1:0] SEL_AX  = pack_class_sel(PAT_AX, 18);
    localparam logic [SEL_MAX_W-1:0] SEL_AA  = pack_class_sel(PAT_AA, 2);
    localparam logic [SEL_MAX_W-1:0] SEL_AB  = pack_class_sel(PAT_AB, 2);
    localparam logic [SEL_MAX_W-1:0] SEL_A   = pack_class_sel(PAT_A, 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sod;
    logic        en;
    logic [63:0] char_class;

    logic        ax_match, ax_pulse, aa_match, aa_pulse, aa1_match, aa1_pulse;
    logic        anc_match, anc_pulse, one_match, one_pulse;
    logic [7:0]  ax_cnt, aa_cnt, anc_cnt, one_cnt;
    logic [0:0]  aa1_cnt;
    logic [15:0] ax_off, aa_off, anc_off, one_off;
    logic [2:0]  aa1_off;
`ifdef NFA_MATCH_OFFSET_EN
    logic [15:0] ax_mo, aa_mo, anc_mo, one_mo;
    logic [2:0]  aa1_mo;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nfa_chain_engine #(.NUM_STATES(18), .CLASS_SEL(SEL_AX[18*6-1:0]), .LOOP_MASK(18'h8)) u_ax (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(ax_match), .match_pulse(ax_pulse), .match_cnt(ax_cnt), .byte_off(ax_off)
`ifdef NFA_MATCH_OFFSET_EN
        , .match_offset(ax_mo)
`endif
    );

    nfa_chain_engine #(.NUM_STATES(2), .CLASS_SEL(SEL_AA[11:0]), .LOOP_MASK(2'b00)) u_aa (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(aa_match), .match_pulse(aa_pulse), .match_cnt(aa_cnt), .byte_off(aa_off)
`ifdef NFA_MATCH_OFFSET_EN
        , .match_offset(aa_mo)
`endif
    );

    nfa_chain_engine #(.NUM_STATES(2), .CLASS_SEL(SEL_AA[11:0]), .LOOP_MASK(2'b00),
                       .CNT_W(1), .OFF_W(3)) u_aa1 (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(aa1_match), .match_pulse(aa1_pulse), .match_cnt(aa1_cnt), .byte_off(aa1_off)
`ifdef NFA_MATCH_OFFSET_EN
        , .match_offset(aa1_mo)
`endif
    );

    nfa_chain_engine #(.NUM_STATES(2), .CLASS_SEL(SEL_AB[11:0]), .LOOP_MASK(2'b00),
                       .ANCHORED(1'b1)) u_anc (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(anc_match), .match_pulse(anc_pulse), .match_cnt(anc_cnt), .byte_off(anc_off)
`ifdef NFA_MATCH_OFFSET_EN
        , .match_offset(anc_mo)
`endif
    );

    nfa_chain_engine #(.NUM_STATES(1), .CLASS_SEL(SEL_A[5:0]), .LOOP_MASK(1'b0)) u_one (
        .clk(clk), .rst_n(rst_n), .sod(sod), .en(en), .char_class(char_class),
        .match(one_match), .match_pulse(one_pulse), .match_cnt(one_cnt), .byte_off(one_off)
`ifdef NFA_MATCH_OFFSET_EN
        , .match_offset(one_mo)
`endif
    );

    typedef struct {
        logic       sod;
        logic       en;
        logic [7:0] ch;
        logic       pulse;
        logic       match;
        int         cnt;
        int         off;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_stimulus(input logic s, input logic e, input logic [7:0] ch);
        @(negedge clk);
        sod        = s;
        en         = e;
        char_class = '0;
        char_class[char_to_class(ch)] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_payload(input string s, input bit with_sod);
        for (int i = 0; i < s.len(); i++) apply_stimulus(with_sod && i == 0, 1'b1, s[i]);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Every payload starts with sod, so only the last byte can carry the single hit.
    function automatic void add_payload(input string s, input bit expect_hit, input int base_off);
        for (int i = 0; i < s.len(); i++) begin
            bit last = expect_hit && (i == s.len() - 1);
            vecs.push_back('{i == 0, 1'b1, s[i], last, last, last ? 1 : 0, base_off + i + 1});
        end
    endfunction

    initial begin
        int pulses_aa;
        int pulses_one;

        rst_n      = 1'b0;
        sod        = 1'b0;
        en         = 1'b0;
        char_class = '0;
        #12;
        check_output("reset ax_match", ax_match, 0);
        check_output("reset ax_pulse", ax_pulse, 0);
        check_output("reset ax_cnt", ax_cnt, 0);
        check_output("reset ax_off", ax_off, 0);
        check_output("reset aa_match", aa_match, 0);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("reset aa_mo", aa_mo, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        add_payload("new   ActiveXObject(", 1'b1, 0);
        vecs.push_back('{1'b0, 1'b0, 8'h78, 1'b0, 1'b1, 1, 20});
        add_payload("newActiveXObject(", 1'b1, 0);
        add_payload("new ActiveX Object(", 1'b0, 0);
        vecs.push_back('{1'b0, 1'b0, 8'h61, 1'b0, 1'b0, 0, 19});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sod, vecs[i].en, vecs[i].ch);
            check_output($sformatf("ax row %0d pulse", i), ax_pulse, vecs[i].pulse);
            check_output($sformatf("ax row %0d match", i), ax_match, vecs[i].match);
            check_output($sformatf("ax row %0d cnt", i), ax_cnt, vecs[i].cnt);
            check_output($sformatf("ax row %0d off", i), ax_off, vecs[i].off);
        end

        // Overlapping "aa" hits, counter saturation and the single-state chain.
        pulses_aa  = 0;
        pulses_one = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(i == 0, 1'b1, "a");
            pulses_aa  += aa_pulse;
            pulses_one += one_pulse;
        end
        check_output("aa pulses", pulses_aa, 3);
        check_output("aa cnt", aa_cnt, 3);
        check_output("aa1 cnt sat", aa1_cnt, 1);
        check_output("one pulses", pulses_one, 4);
        check_output("one cnt", one_cnt, 4);
        check_output("aa1 off", aa1_off, 4);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("aa first offset", aa_mo, 1);
`endif
        send_payload("xxxxx", 1'b0);
        check_output("aa1 off sat", aa1_off, 7);
        check_output("aa off", aa_off, 9);
        check_output("aa match sticky", aa_match, 1);

        // Anchored chain may only start on payload byte 0.
        send_payload("xab", 1'b1);
        check_output("anc unanchored start", anc_match, 0);
        send_payload("ab", 1'b1);
        check_output("anc pulse", anc_pulse, 1);
        check_output("anc match", anc_match, 1);
        check_output("anc cnt", anc_cnt, 1);

        send_payload("xxxxxaa", 1'b1);
        check_output("offset match", aa_match, 1);
        check_output("offset cnt", aa_cnt, 1);
        check_output("offset off", aa_off, 7);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("offset mo", aa_mo, 6);
`endif

        // Same payload with en held low mid-pattern.
        send_payload("xxxxxa", 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b0, "a");
            check_output($sformatf("gap %0d off", i), aa_off, 6);
            check_output($sformatf("gap %0d pulse", i), aa_pulse, 0);
            check_output($sformatf("gap %0d match", i), aa_match, 0);
        end
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("gap hit pulse", aa_pulse, 1);
        check_output("gap hit off", aa_off, 7);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("gap hit mo", aa_mo, 6);
`endif
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("gap second cnt", aa_cnt, 2);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("gap mo held", aa_mo, 6);
`endif

        // sod without a byte clears everything including chain state.
        apply_stimulus(1'b1, 1'b0, "a");
        check_output("sod idle match", aa_match, 0);
        check_output("sod idle cnt", aa_cnt, 0);
        check_output("sod idle off", aa_off, 0);
`ifdef NFA_MATCH_OFFSET_EN
        check_output("sod idle mo", aa_mo, 0);
`endif
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("after sod idle pulse", aa_pulse, 0);
        check_output("after sod idle off", aa_off, 1);
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("after sod idle hit", aa_pulse, 1);

        // Asynchronous reset mid-payload, then resume without sod.
        send_payload("aa", 1'b1);
        check_output("pre reset pulse", aa_pulse, 1);
        @(negedge clk);
        en  = 1'b0;
        sod = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_output("async reset match", aa_match, 0);
        check_output("async reset pulse", aa_pulse, 0);
        check_output("async reset cnt", aa_cnt, 0);
        check_output("async reset off", aa_off, 0);
        #1 rst_n = 1'b1;
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("resume first pulse", aa_pulse, 0);
        check_output("resume first off", aa_off, 1);
        apply_stimulus(1'b0, 1'b1, "a");
        check_output("resume hit pulse", aa_pulse, 1);
        check_output("resume match", aa_match, 1);
        check_output("resume cnt", aa_cnt, 1);
        check_output("resume off", aa_off, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nfa_chain_engine.md
Name: nfa_chain_engine

Overview:
- Parametrised payload-matching engine for a linear NFA: a chain of one-hot character-class states with optional per-state repeat (`x*`).
- Consumes the shared per-byte class-decode bus and raises a sticky match per payload.
- Also counts match hits and reports the byte offset of the first match.
- Sits beside the other payload engines; fed by the common char decoder, cleared per payload by sod.

Parameters:
- NUM_STATES, 40, number of chain states (>=1); the last state's hit is the match.
- NUM_CLASSES, 64, width of the class-decode input bus.
- CLS_IDX_W, 6, width of one class index (>= clog2(NUM_CLASSES)).
- CLASS_SEL, 0, packed NUM_STATES*CLS_IDX_W vector; field k selects the class bit tested by state k (state 0 in the LSBs).
- LOOP_MASK, 0, NUM_STATES bits; bit k=1 makes state k a zero-or-more repeat.
- ANCHORED, 0, 1 = chain may start only on the first byte of a payload.
- OFF_W, 16, byte-offset counter width.
- CNT_W, 8, hit-counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sod  in  1  start of data; qualifies the first byte of a payload and synchronously clears per-payload state
- en  in  1  byte valid; only cycles with en=1 advance the engine
- char_class  in  NUM_CLASSES  one-hot/multi-hot class decode of the current byte
- match  out  1  sticky match for the current payload
- match_pulse  out  1  one-cycle pulse per hit
- match_cnt  out  CNT_W  saturating hit count for the current payload
- byte_off  out  OFF_W  saturating count of bytes consumed in the current payload

Behaviour:
- Reset: all state flops, match, match_pulse, match_cnt, byte_off and match_offset = 0.
- Per-state class bit: c_k = char_class[CLASS_SEL[k]].
- Entry enable e_k:
  - e_0 = 1 when ANCHORED=0.
  - e_0 = first byte when ANCHORED=1, i.e. (sod & en) or (en and byte_off==0 since the last sod).
  - e_{k+1} = LOOP_MASK[k] ? (e_k | s_k) : s_k.
- State update on an en cycle: s_k <= c_k & (LOOP_MASK[k] ? (e_k | s_k) : e_k).
- Final state: s_{N-1} is not stored. hit = en & c_{N-1} & (LOOP_MASK[N-1] ? (e_{N-1} | s_{N-1}) : e_{N-1}).
- Loop chains: consecutive looped states chain combinationally.
- A looped last state keeps its flop, which feeds hit.
- With en=0, every register holds its value and match_pulse = 0.
- sod handling:
  - sod=1 & en=1: all s_k, match, match_cnt and match_offset are treated as 0. The byte is then evaluated as payload byte 0, and byte_off <= 1.
  - sod=1 & en=0: clears everything, byte_off <= 0.
- Latency: a byte presented at cycle t with hit=1 gives match_pulse=1 at t+1, match=1 from t+1, and match_cnt increments at t+1.
- Overlapping matches: each hit cycle is counted.
- match stays high until the next sod or reset.
- Saturation: match_cnt saturates at 2^CNT_W-1; byte_off saturates at 2^OFF_W-1.
- Reset asserted mid-payload clears everything immediately. The engine resumes only after rst_n deasserts; a payload without a fresh sod continues from the cleared state.
- NUM_STATES=1: the single state's class alone produces hits.

Optional Feature:
- Macro NFA_MATCH_OFFSET_EN.
- Defined:
  - Adds output port match_offset (OFF_W).
  - Captures the byte index (0-based, byte_off value before increment) of the byte producing the first hit after sod.
  - Holds until the next sod; reset and sod clear it to 0.
- Undefined: the port and its register are absent; everything else is unchanged.

Decomposition:
- Shared package nfa_pkg: class-index width helper, class enumeration constants for the decoder bus (space, `.`, `(` and alpha classes), and a packing function for CLASS_SEL.
- One natural sub-module, nfa_chain_state: one state (class AND, optional loop OR, flop with sync clear and enable), generated NUM_STATES-1 times.

Test Plan:
- `/new\s*ActiveXObject\(/` encoding (LOOP_MASK on the `\s` state), payload "new   ActiveXObject(" after sod -> match_pulse one cycle after `(`, match=1, match_cnt=1.
- Same pattern, payload "newActiveXObject(" (zero spaces) -> match asserted; payload "new ActiveX Object(" -> match stays 0.
- Pattern "aa", payload "aaaa" -> three match_pulses, match_cnt=3; with CNT_W=1 -> match_cnt saturates at 1.
- ANCHORED=1, pattern "ab", payload "xab" -> no match; next payload "ab" with sod on `a` -> match.
- Match, then sod coincident with en on byte `n` -> match=0 and match_cnt=0 on the next cycle, and `n` starts a new chain; rst_n pulsed mid-chain -> all outputs 0 asynchronously.
- With NFA_MATCH_OFFSET_EN, 5 filler bytes + "aa" (pattern "aa") -> match_offset=6; en held low for 3 cycles mid-pattern -> same result, byte_off unchanged while en=0.
